// File: rtl/reg_access_sequencer_pkg.sv
// Shared definitions for the register-access sequencer: opcodes, FSM states,
// the latched command record and the signed-overflow helper.
package reg_seq_defs;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_LI  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
  } seq_cmd_t;

  // Two same-signed addends producing a result of the other sign.
  // For subtraction pass the inverted msb of the subtrahend.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/reg_access_sequencer_alu.sv
// Combinational ALU of the sequencer: add/sub/and/or/load-immediate with
// signed-overflow flag on add and subtract only.
module seq_alu
  import reg_seq_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [31:0] imm,
  output logic [31:0] result,
  output logic        ovf
);

  logic [31:0] sum_s;
  logic [31:0] diff_s;

  assign sum_s  = opA + opB;
  assign diff_s = opA - opB;

  // Select the operation; unused opcodes behave as a load of zero.
  always_comb begin
    result = 32'd0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum_s;
        ovf    = signed_ovf(opA[31], opB[31], sum_s[31]);
      end
      OP_SUB: begin
        result = diff_s;
        ovf    = signed_ovf(opA[31], ~opB[31], diff_s[31]);
      end
      OP_AND:  result = opA & opB;
      OP_OR:   result = opA | opB;
      OP_LI:   result = imm;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/reg_access_sequencer.sv
// Four-state register-file access sequencer: accept a command in IDLE, read
// operands in READ, compute in EXEC, write back in WRITE. All outputs registered.
module reg_access_sequencer
  import reg_seq_defs::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [2:0]  cmdOp,
  input  logic [4:0]  cmdRD,
  input  logic [4:0]  cmdRS,
  input  logic [4:0]  cmdRT,
  input  logic [31:0] cmdImm,
  output logic [4:0]  RS,
  output logic [4:0]  RT,
  input  logic [31:0] dataRS,
  input  logic [31:0] dataRT,
  output logic [4:0]  RD,
  output logic [31:0] dataRD,
  output logic        RW,
  output logic        done,
  output logic [31:0] result,
  output logic        ovf
);

  seq_state_e  state_q, state_d;
  seq_cmd_t    cmd_q, cmd_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_rd_q, data_rd_d;
  logic        rw_q, rw_d;
  logic        done_q, done_d;
  logic        cmd_ready_q, cmd_ready_d;

  logic [31:0] alu_result_s;
  logic        alu_ovf_s;

  seq_alu u_alu (
    .op     (cmd_q.op),
    .opA    (op_a_q),
    .opB    (op_b_q),
    .imm    (cmd_q.imm),
    .result (alu_result_s),
    .ovf    (alu_ovf_s)
  );

  // Next-state and next-output logic; RW/done are single-cycle pulses in WRITE.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    data_rd_d = data_rd_q;
    rw_d      = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // cmd_ready_q gates acceptance so the first cycle after reset is never used.
        if (cmd_ready_q && cmdValid) begin
          cmd_d   = '{op: cmdOp, rd: cmdRD, rs: cmdRS, rt: cmdRT, imm: cmdImm};
          rs_d    = cmdRS;
          rt_d    = cmdRT;
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        op_a_d  = dataRS;
        op_b_d  = dataRT;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        result_d  = alu_result_s;
        ovf_d     = alu_ovf_s;
        rd_d      = cmd_q.rd;
        data_rd_d = alu_result_s;
        rw_d      = (cmd_q.rd != 5'd0);
        done_d    = 1'b1;
        state_d   = ST_WRITE;
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset abandons any command in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      result_q    <= 32'd0;
      ovf_q       <= 1'b0;
      rs_q        <= 5'd0;
      rt_q        <= 5'd0;
      rd_q        <= 5'd0;
      data_rd_q   <= 32'd0;
      rw_q        <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      data_rd_q   <= data_rd_d;
      rw_q        <= rw_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmdReady = cmd_ready_q;
  assign RS       = rs_q;
  assign RT       = rt_q;
  assign RD       = rd_q;
  assign dataRD   = data_rd_q;
  assign RW       = rw_q;
  assign done     = done_q;
  assign result   = result_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Self-checking bench: bench-owned register file plus an architectural model
// (array of register values, plain signed arithmetic) checked cycle by cycle.
module tb_reg_access_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        cmdValid;
  logic        cmdReady;
  logic [2:0]  cmdOp;
  logic [4:0]  cmdRD, cmdRS, cmdRT;
  logic [31:0] cmdImm;
  logic [4:0]  RS, RT, RD;
  logic [31:0] dataRS, dataRT, dataRD;
  logic        RW, done, ovf;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf       [32];
  logic [31:0] model_rf [32];
  logic        load_all;

  logic [31:0] prev_result, prev_data;
  logic [4:0]  prev_rd;
  logic        prev_ovf;

  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  reg_access_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOp(cmdOp), .cmdRD(cmdRD), .cmdRS(cmdRS), .cmdRT(cmdRT), .cmdImm(cmdImm),
    .RS(RS), .RT(RT), .dataRS(dataRS), .dataRT(dataRT),
    .RD(RD), .dataRD(dataRD), .RW(RW), .done(done), .result(result), .ovf(ovf)
  );

  always #5 Clk = ~Clk;

  assign dataRS = rf[RS];
  assign dataRT = rf[RT];

  always @(posedge Clk) begin
    if (load_all) begin
      for (int i = 0; i < 32; i++) rf[i] <= model_rf[i];
    end else if (RW) begin
      rf[RD] <= dataRD;
    end
  end

  // Architectural meaning of one command, using 64-bit signed arithmetic for overflow.
  function automatic void model_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] imm, output logic [31:0] r, output logic o);
    longint sa, sb, full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    o  = 1'b0;
    case (op)
      3'd0: begin full = sa + sb; r = 32'(full); o = (full > MAX_S) || (full < MIN_S); end
      3'd1: begin full = sa - sb; r = 32'(full); o = (full > MAX_S) || (full < MIN_S); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = imm;
      default: r = 32'd0;
    endcase
  endfunction

  task automatic clear_prev();
    prev_result = 32'd0; prev_data = 32'd0; prev_rd = 5'd0; prev_ovf = 1'b0;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [31:0] imm, input bit hold);
    logic [31:0] exp_r;
    logic        exp_o;
    @(negedge Clk);
    for (int i = 0; i < 8 && cmdReady !== 1'b1; i++) @(negedge Clk);
    checks++; if (cmdReady !== 1'b1) begin errors++; $display("FAIL ready_idle: cmdReady=%b want 1", cmdReady); end
    model_exec(op, model_rf[rs], model_rf[rt], imm, exp_r, exp_o);
    cmdValid = 1'b1; cmdOp = op; cmdRD = rd; cmdRS = rs; cmdRT = rt; cmdImm = imm;
    @(negedge Clk); // READ
    if (hold) begin
      cmdOp = 3'($urandom); cmdRD = 5'($urandom); cmdRS = 5'($urandom); cmdRT = 5'($urandom); cmdImm = $urandom;
    end else begin
      cmdValid = 1'b0;
    end
    checks++; if (cmdReady !== 1'b0) begin errors++; $display("FAIL ready_read: cmdReady=%b want 0", cmdReady); end
    checks++; if (RS !== rs) begin errors++; $display("FAIL rs_read: RS=%0d want %0d", RS, rs); end
    checks++; if (RT !== rt) begin errors++; $display("FAIL rt_read: RT=%0d want %0d", RT, rt); end
    checks++; if (RW !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL pulse_read: RW=%b done=%b want 0 0", RW, done); end
    checks++; if (result !== prev_result) begin errors++; $display("FAIL result_hold: result=%h want %h", result, prev_result); end
    checks++; if (RD !== prev_rd) begin errors++; $display("FAIL rd_hold: RD=%0d want %0d", RD, prev_rd); end
    @(negedge Clk); // EXEC
    checks++; if (cmdReady !== 1'b0) begin errors++; $display("FAIL ready_exec: cmdReady=%b want 0", cmdReady); end
    checks++; if (RW !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL pulse_exec: RW=%b done=%b want 0 0", RW, done); end
    checks++; if (ovf !== prev_ovf) begin errors++; $display("FAIL ovf_hold: ovf=%b want %b", ovf, prev_ovf); end
    checks++; if (dataRD !== prev_data) begin errors++; $display("FAIL data_hold: dataRD=%h want %h", dataRD, prev_data); end
    @(negedge Clk); // WRITE
    checks++; if (cmdReady !== 1'b0) begin errors++; $display("FAIL ready_write: cmdReady=%b want 0", cmdReady); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_write: done=%b want 1", done); end
    checks++; if (RW !== (rd != 5'd0)) begin errors++; $display("FAIL rw_write: RW=%b want %b (rd=%0d)", RW, (rd != 5'd0), rd); end
    checks++; if (RD !== rd) begin errors++; $display("FAIL rd_write: RD=%0d want %0d", RD, rd); end
    checks++; if (dataRD !== exp_r) begin errors++; $display("FAIL data_write: op=%0d dataRD=%h want %h", op, dataRD, exp_r); end
    checks++; if (result !== exp_r) begin errors++; $display("FAIL result_write: op=%0d result=%h want %h", op, result, exp_r); end
    checks++; if (ovf !== exp_o) begin errors++; $display("FAIL ovf_write: op=%0d ovf=%b want %b", op, ovf, exp_o); end
    prev_result = exp_r; prev_data = exp_r; prev_rd = rd; prev_ovf = exp_o;
    if (rd != 5'd0) model_rf[rd] = exp_r;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; cmdValid = 1'b0; cmdOp = 3'd0; cmdRD = 5'd0; cmdRS = 5'd0; cmdRT = 5'd0; cmdImm = 32'd0;
    model_rf[0] = 32'd0;
    for (int i = 1; i < 32; i++) model_rf[i] = $urandom;
    load_all = 1'b1;
    repeat (2) @(negedge Clk);
    load_all = 1'b0;
    cmdValid = 1'b1;
    checks++; if (cmdReady !== 1'b0 || RW !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctrl: ready=%b RW=%b done=%b want 0 0 0", cmdReady, RW, done); end
    checks++; if (result !== 32'd0 || ovf !== 1'b0 || dataRD !== 32'd0) begin errors++; $display("FAIL reset_data: result=%h ovf=%b dataRD=%h want 0", result, ovf, dataRD); end
    checks++; if (RS !== 5'd0 || RT !== 5'd0 || RD !== 5'd0) begin errors++; $display("FAIL reset_addr: RS=%0d RT=%0d RD=%0d want 0", RS, RT, RD); end
    Reset_n = 1'b1;
    @(negedge Clk);
    cmdValid = 1'b0;
    checks++; if (cmdReady !== 1'b1) begin errors++; $display("FAIL ready_after_reset: cmdReady=%b want 1", cmdReady); end
    clear_prev();
  endtask

  task automatic test_li_pair();
    run_cmd(3'd4, 5'd5, 5'($urandom), 5'($urandom), 32'd10, 1'b0);
    run_cmd(3'd4, 5'd6, 5'($urandom), 5'($urandom), 32'd5, 1'b0);
  endtask

  task automatic test_add();
    run_cmd(3'd0, 5'd7, 5'd5, 5'd6, 32'($urandom), 1'b0);
  endtask

  task automatic test_rd_zero();
    run_cmd(3'd4, 5'd0, 5'd3, 5'd4, 32'd100, 1'b0);
    run_cmd(3'd0, 5'd8, 5'd0, 5'd0, 32'($urandom), 1'b0);
  endtask

  task automatic test_overflow();
    run_cmd(3'd4, 5'd1, 5'd0, 5'd0, 32'h7FFF_FFFF, 1'b0);
    run_cmd(3'd4, 5'd2, 5'd0, 5'd0, 32'h0000_0001, 1'b0);
    run_cmd(3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    run_cmd(3'd1, 5'd4, 5'd2, 5'd1, 32'd0, 1'b0);
    run_cmd(3'd1, 5'd10, 5'd3, 5'd2, 32'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [4:0] last_rd = 5'd1;
    for (int i = 0; i < 16; i++) begin
      logic [4:0] rd = 5'($urandom);
      logic [4:0] rs = (i % 2 == 1) ? last_rd : 5'($urandom);
      run_cmd(3'($urandom_range(4, 0)), rd, rs, 5'($urandom), $urandom, 1'b1);
      last_rd = rd;
    end
    cmdValid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_cmd(3'($urandom_range(7, 0)), 5'($urandom), 5'($urandom), 5'($urandom), $urandom,
              1'($urandom_range(1, 0)));
    end
    cmdValid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit rw_seen = 1'b0;
    run_cmd(3'd4, 5'd9, 5'd0, 5'd0, 32'hDEAD_BEEF, 1'b0);
    @(negedge Clk);
    for (int i = 0; i < 8 && cmdReady !== 1'b1; i++) @(negedge Clk);
    cmdValid = 1'b1; cmdOp = 3'd0; cmdRD = 5'd9; cmdRS = 5'd1; cmdRT = 5'd2; cmdImm = 32'd0;
    @(negedge Clk); // READ
    cmdValid = 1'b0;
    @(negedge Clk); // EXEC
    #1 Reset_n = 1'b0;
    #1;
    checks++; if (RW !== 1'b0 || done !== 1'b0 || cmdReady !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: RW=%b done=%b ready=%b want 0", RW, done, cmdReady); end
    checks++; if (result !== 32'd0 || ovf !== 1'b0 || RD !== 5'd0 || dataRD !== 32'd0) begin errors++; $display("FAIL midreset_data: result=%h ovf=%b RD=%0d dataRD=%h want 0", result, ovf, RD, dataRD); end
    repeat (3) begin @(negedge Clk); if (RW !== 1'b0) rw_seen = 1'b1; end
    Reset_n = 1'b1;
    @(negedge Clk);
    checks++; if (cmdReady !== 1'b1) begin errors++; $display("FAIL midreset_ready: cmdReady=%b want 1", cmdReady); end
    repeat (4) begin @(negedge Clk); if (RW !== 1'b0) rw_seen = 1'b1; end
    checks++; if (rw_seen !== 1'b0) begin errors++; $display("FAIL midreset_rw: RW seen=%b want 0", rw_seen); end
    checks++; if (rf[9] !== model_rf[9]) begin errors++; $display("FAIL midreset_r9: r9=%h want %h", rf[9], model_rf[9]); end
    clear_prev();
    run_cmd(3'd0, 5'd11, 5'd9, 5'd9, 32'd0, 1'b0);
  endtask

  task automatic test_final_rf();
    @(negedge Clk);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (rf[i] !== model_rf[i]) begin errors++; $display("FAIL regfile: r%0d=%h want %h", i, rf[i], model_rf[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_li_pair();
    test_add();
    test_rd_zero();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_final_rf();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
